// File: rtl/pipearch_result_packer.sv
// Packs 32-bit result words into 512-bit lines, queues them in a small line FIFO and issues
// them as valid/ready line writes at base + line index; pulses op_done when all are written.
module pipearch_result_packer #(
    parameter int unsigned WORD_WIDTH          = 32,
    parameter int unsigned LOG2_WORDS_PER_LINE = 4,
    parameter int unsigned LOG2_FIFO_DEPTH     = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          op_start,
    output logic                                          op_done,
    input  logic [31:0]                                   regs0,
    input  logic [31:0]                                   regs1,
    input  logic                                          in_we,
    input  logic [WORD_WIDTH-1:0]                         in_wdata,
    output logic                                          in_almostfull,
    output logic                                          wr_valid,
    output logic [31:0]                                   wr_addr,
    output logic [(WORD_WIDTH<<LOG2_WORDS_PER_LINE)-1:0]  wr_data,
    input  logic                                          wr_ready,
    output logic                                          err_overflow
);

    localparam int unsigned LINE_WIDTH = WORD_WIDTH << LOG2_WORDS_PER_LINE;
    localparam int unsigned DEPTH      = 1 << LOG2_FIFO_DEPTH;
    localparam int unsigned AF_LEVEL   = DEPTH - 2;
    localparam logic [LOG2_WORDS_PER_LINE-1:0] LAST_LANE = '1;

    typedef enum logic [1:0] {StIdle, StPack, StDrain, StDone} state_e;

    state_e                         state_q, state_d;
    logic [31:0]                    n_q, n_d;
    logic [31:0]                    base_q, base_d;
    logic [31:0]                    word_cnt_q, word_cnt_d;
    logic [31:0]                    line_idx_q, line_idx_d;
    logic [LOG2_WORDS_PER_LINE-1:0] lane_q, lane_d, lane_eff;
    logic [LINE_WIDTH-1:0]          pack_q, pack_d;
    logic                           pend_q, pend_d;
    logic                           last_q, last_d;
    logic                           err_q, err_d;
    logic                           af_q, af_d;
    logic                           done_q, done_d;
    logic [LOG2_FIFO_DEPTH:0]       count_q, count_d;
    logic [LOG2_FIFO_DEPTH-1:0]     wr_ptr_q, rd_ptr_q;
    logic [31:0]                    addr_mem [DEPTH];
    logic [LINE_WIDTH-1:0]          data_mem [DEPTH];
    logic                           fifo_full, push, pop;
    int unsigned                    lane_ofs;

    assign fifo_full = (count_q == (LOG2_FIFO_DEPTH+1)'(DEPTH));
    // A completed line leaves the pack buffer only when a FIFO slot is free.
    assign push      = (state_q == StPack) && pend_q && !fifo_full;
    assign wr_valid  = (count_q != '0);
    assign pop       = wr_valid && wr_ready;
    assign wr_addr   = addr_mem[rd_ptr_q];
    assign wr_data   = data_mem[rd_ptr_q];

    assign op_done       = done_q;
    assign in_almostfull = af_q;
    assign err_overflow  = err_q;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        base_d     = base_q;
        word_cnt_d = word_cnt_q;
        line_idx_d = line_idx_q;
        lane_d     = lane_q;
        lane_eff   = lane_q;
        pack_d     = pack_q;
        pend_d     = pend_q;
        last_d     = last_q;
        err_d      = err_q;
        lane_ofs   = 0;

        unique case (state_q)
            StIdle: begin
                if (op_start) begin
                    n_d        = regs0;
                    base_d     = regs1;
                    word_cnt_d = '0;
                    line_idx_d = '0;
                    lane_d     = '0;
                    pack_d     = '0;
                    pend_d     = 1'b0;
                    last_d     = 1'b0;
                    state_d    = (regs0 == '0) ? StDone : StPack;
                end
            end
            StPack: begin
                if (push) begin
                    pack_d     = '0;
                    lane_d     = '0;
                    lane_eff   = '0;
                    pend_d     = 1'b0;
                    line_idx_d = line_idx_q + 32'd1;
                    if (last_q) begin
                        state_d = StDrain;
                    end
                end
                if (in_we && (word_cnt_q != n_q)) begin
                    if (!pend_q || push) begin
                        lane_ofs   = 32'(lane_eff) * WORD_WIDTH;
                        pack_d[lane_ofs +: WORD_WIDTH] = in_wdata;
                        lane_d     = lane_eff + LOG2_WORDS_PER_LINE'(1);
                        word_cnt_d = word_cnt_q + 32'd1;
                        if ((lane_eff == LAST_LANE) || (word_cnt_q == n_q - 32'd1)) begin
                            pend_d = 1'b1;
                            last_d = (word_cnt_q == n_q - 32'd1);
                        end
                    end else begin
                        // Held line still owns the buffer: the word has nowhere to go.
                        err_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (count_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        count_d = count_q + (LOG2_FIFO_DEPTH+1)'(push) - (LOG2_FIFO_DEPTH+1)'(pop);
        af_d    = (state_d != StPack) ||
                  (({1'b0, count_d} + (LOG2_FIFO_DEPTH+2)'(pend_d)) >=
                   (LOG2_FIFO_DEPTH+2)'(AF_LEVEL));
        done_d  = (state_q == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            n_q        <= '0;
            base_q     <= '0;
            word_cnt_q <= '0;
            line_idx_q <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
            pend_q     <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            af_q       <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            base_q     <= base_d;
            word_cnt_q <= word_cnt_d;
            line_idx_q <= line_idx_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            pend_q     <= pend_d;
            last_q     <= last_d;
            err_q      <= err_d;
            af_q       <= af_d;
            done_q     <= done_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[wr_ptr_q] <= base_q + line_idx_q;
                data_mem[wr_ptr_q] <= pack_q;
                wr_ptr_q           <= wr_ptr_q + LOG2_FIFO_DEPTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + LOG2_FIFO_DEPTH'(1);
            end
        end
    end

endmodule
